// File: rtl/noc_flit_pkg.sv
// Shared flit-format definitions for the NoC link: flit type codes, field
// offsets inside a 34-bit flit, and the transmitter state encoding. The
// vc_buffer decode side imports the same package so both ends agree.
package noc_flit_pkg;

    localparam int FLIT_W  = 34;
    localparam int DATA_W  = 32;
    localparam int COORD_W = 4;
    localparam int LEN_W   = 4;
    localparam int VC_W    = 2;

    localparam logic [1:0] FLIT_HEAD = 2'b00;
    localparam logic [1:0] FLIT_BODY = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    localparam int TYPE_MSB    = 33;
    localparam int TYPE_LSB    = 32;
    localparam int ROUTE_X_MSB = 29;
    localparam int ROUTE_X_LSB = 26;
    localparam int ROUTE_Y_MSB = 25;
    localparam int ROUTE_Y_LSB = 22;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_HEAD  = 2'd1,
        TX_DATA  = 2'd2,
        TX_DRAIN = 2'd3
    } tx_state_t;

    // Builds a HEAD flit: route coordinates in their fields, everything else zero.
    function automatic logic [FLIT_W-1:0] make_head(input logic [COORD_W-1:0] dst_x,
                                                    input logic [COORD_W-1:0] dst_y);
        logic [FLIT_W-1:0] flit;
        flit = '0;
        flit[TYPE_MSB:TYPE_LSB]       = FLIT_HEAD;
        flit[ROUTE_X_MSB:ROUTE_X_LSB] = dst_x;
        flit[ROUTE_Y_MSB:ROUTE_Y_LSB] = dst_y;
        return flit;
    endfunction

endpackage

// File: rtl/noc_flit_oreg.sv
// Single-entry valid/ready output register for link senders. It accepts a
// new flit whenever it is empty or its current flit is being taken, and
// holds data and valid unchanged while the receiver stalls.
module noc_flit_oreg #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         load_ok_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         ready_i
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Next-state: load when the slot frees up; a missing input lets valid drop (bubble).
    always_comb begin
        load_ok_o = !valid_q || ready_i;
        valid_d   = valid_q;
        data_d    = data_q;
        if (load_ok_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    // Register update with synchronous reset clearing the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/ni_flit_tx.sv
// Network-interface flit transmitter. Takes a packet request plus a stream
// of data words and emits HEAD/BODY/TAIL flits on the router input link.
// Requests with an all-zero route are flagged and their words discarded.
module ni_flit_tx
    import noc_flit_pkg::*;
(
    input  logic               clk,
    input  logic               arst,
    input  logic               pkt_valid_i,
    output logic               pkt_ready_o,
    input  logic [COORD_W-1:0] pkt_dst_x_i,
    input  logic [COORD_W-1:0] pkt_dst_y_i,
    input  logic [LEN_W-1:0]   pkt_len_i,
    input  logic [VC_W-1:0]    pkt_vc_i,
    input  logic               word_valid_i,
    output logic               word_ready_o,
    input  logic [DATA_W-1:0]  word_data_i,
    output logic [FLIT_W-1:0]  fdata_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [VC_W-1:0]    vc_id_o,
    output logic               err_o
);

    tx_state_t          state_q, state_d;
    logic [COORD_W-1:0] dst_x_q, dst_x_d;
    logic [COORD_W-1:0] dst_y_q, dst_y_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [VC_W-1:0]    vc_q, vc_d;
    logic               err_q, err_d;

    logic               flit_valid;
    logic [FLIT_W-1:0]  flit_data;
    logic               load_ok;

    // FSM next-state, word counter and flit assembly for the output register.
    always_comb begin
        state_d      = state_q;
        dst_x_d      = dst_x_q;
        dst_y_d      = dst_y_q;
        remaining_d  = remaining_q;
        vc_d         = vc_q;
        err_d        = 1'b0;
        pkt_ready_o  = 1'b0;
        word_ready_o = 1'b0;
        flit_valid   = 1'b0;
        flit_data    = '0;

        case (state_q)
            TX_IDLE: begin
                pkt_ready_o = 1'b1;
                if (pkt_valid_i) begin
                    dst_x_d     = pkt_dst_x_i;
                    dst_y_d     = pkt_dst_y_i;
                    vc_d        = pkt_vc_i;
                    remaining_d = (pkt_len_i == '0) ? LEN_W'(1) : pkt_len_i;
                    if (pkt_dst_x_i == '0 && pkt_dst_y_i == '0) begin
                        err_d   = 1'b1;
                        state_d = TX_DRAIN;
                    end else begin
                        state_d = TX_HEAD;
                    end
                end
            end
            TX_HEAD: begin
                flit_valid = 1'b1;
                flit_data  = make_head(dst_x_q, dst_y_q);
                if (load_ok) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                word_ready_o = load_ok;
                flit_valid   = word_valid_i;
                flit_data    = {(remaining_q > LEN_W'(1)) ? FLIT_BODY : FLIT_TAIL, word_data_i};
                if (word_valid_i && load_ok) begin
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                    if (remaining_q <= LEN_W'(1)) begin
                        state_d = TX_IDLE;
                    end
                end
            end
            TX_DRAIN: begin
                word_ready_o = 1'b1;
                if (word_valid_i) begin
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                    if (remaining_q <= LEN_W'(1)) begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // State, packet context and error pulse registers; reset abandons any packet.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q     <= TX_IDLE;
            dst_x_q     <= '0;
            dst_y_q     <= '0;
            remaining_q <= '0;
            vc_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dst_x_q     <= dst_x_d;
            dst_y_q     <= dst_y_d;
            remaining_q <= remaining_d;
            vc_q        <= vc_d;
            err_q       <= err_d;
        end
    end

    noc_flit_oreg #(
        .W (FLIT_W)
    ) u_oreg (
        .clk         (clk),
        .rst         (arst),
        .in_valid_i  (flit_valid),
        .in_data_i   (flit_data),
        .load_ok_o   (load_ok),
        .out_valid_o (valid_o),
        .out_data_o  (fdata_o),
        .ready_i     (ready_i)
    );

    assign vc_id_o = vc_q;
    assign err_o   = err_q;

endmodule
